// File: rtl/mem_access_unit.sv
// MIPS MEM-stage load/store unit: store lane steering, load extension, alignment check, one req/ack bus cycle.
// Latency: done 2+k cycles after start for an ack k cycles into REQ; a misaligned access completes 1 cycle after start.
// Backpressure: busy stalls the pipeline until done; bus_req holds until bus_ack. Define MAU_TIMEOUT_EN for an ack timeout (bus_err).
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        align_exc,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        req_ok;
  logic        misaligned;
  logic        accept;
  logic        ack_hit;
  logic        tmo_hit;
  logic [3:0]  be_s;
  logic [31:0] wd_s;
  logic [15:0] lane;
  logic [31:0] ld_ext;

  logic        we_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic        exc_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [31:0] rdata_q;

  // Exactly one of read/write with a legal size is a real request; anything else is dropped.
  assign req_ok     = start && (mem_read ^ mem_write) && (size != 2'd0);
  assign misaligned = ((size == 2'd2) && addr[0]) ||
                      ((size == 2'd3) && (addr[1:0] != 2'b00));
  assign accept     = (state_q == S_IDLE) && req_ok;
  assign ack_hit    = (state_q == S_REQ) && bus_ack;

`ifdef MAU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // The cycle that would bring the count to TIMEOUT_CYCLES abandons the access instead.
  assign tmo_hit = (state_q == S_REQ) && !bus_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count REQ cycles spent waiting for ack; restart from zero for each bus access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && !misaligned) begin
      cnt_q <= '0;
    end else if ((state_q == S_REQ) && !bus_ack) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Remember whether the access ended by timeout so bus_err pulses alongside done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end

  assign bus_err = (state_q == S_DONE) && err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign tmo_hit            = 1'b0;
  assign bus_err            = 1'b0;
`endif

  // Store steering: replicate the narrow datum across lanes and enable only the addressed bytes.
  always_comb begin
    be_s = 4'b1111;
    wd_s = 32'h0;
    if (mem_write) begin
      case (size)
        2'd1: begin
          be_s = 4'b0001 << addr[1:0];
          wd_s = {4{wdata[7:0]}};
        end
        2'd2: begin
          be_s = 4'b0011 << addr[1:0];
          wd_s = {2{wdata[15:0]}};
        end
        default: begin
          be_s = 4'b1111;
          wd_s = wdata;
        end
      endcase
    end
  end

  assign lane = 16'(bus_rdata >> {off_q, 3'b000});

  // Load extraction: shift the addressed lane down, then sign- or zero-extend narrow loads.
  always_comb begin
    ld_ext = bus_rdata;
    case (size_q)
      2'd1:    ld_ext = {{24{lane[7] & ~uns_q}}, lane[7:0]};
      2'd2:    ld_ext = {{16{lane[15] & ~uns_q}}, lane[15:0]};
      default: ld_ext = bus_rdata;
    endcase
  end

  // State register; reset drops out of REQ immediately so bus_req falls asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    bus_req   = 1'b0;
    align_exc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          state_d = misaligned ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || tmo_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        align_exc = exc_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the access on acceptance so the bus sees stable fields for the whole REQ phase,
  // and capture load data on ack only; misaligned accesses and stores leave rdata untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      uns_q   <= 1'b0;
      exc_q   <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wd_q    <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        exc_q <= misaligned;
        if (!misaligned) begin
          we_q   <= mem_write;
          size_q <= size;
          off_q  <= addr[1:0];
          uns_q  <= ld_unsigned;
          addr_q <= {addr[31:2], 2'b00};
          be_q   <= be_s;
          wd_q   <= wd_s;
        end
      end
      if (ack_hit && !we_q) begin
        rdata_q <= ld_ext;
      end
    end
  end

  assign rdata     = rdata_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wd_q;

endmodule
